// File: rtl/gpio_bus_pkg.sv
// Shared encodings for the GPIO bus master: command ops, register indices, FSM states.
// ST_VFY is only reachable when READBACK_VERIFY_EN is defined.
package gpio_bus_pkg;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_POLL  = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    localparam logic [1:0] ADDR_GPI1 = 2'd0;
    localparam logic [1:0] ADDR_GPI2 = 2'd1;
    localparam logic [1:0] ADDR_GPO1 = 2'd2;
    localparam logic [1:0] ADDR_GPO2 = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WR   = 3'd2,
        ST_POLL = 3'd3,
        ST_RESP = 3'd4,
        ST_VFY  = 3'd5
    } state_t;

    // Input registers are read-only; writing them is a client error.
    function automatic logic is_input_reg(input logic [1:0] addr);
        return (addr == ADDR_GPI1) || (addr == ADDR_GPI2);
    endfunction

endpackage

// File: rtl/gpio_poll_cmp.sv
// Poll helper: masked compare of read data plus a saturating read counter.
// hit/timeout are combinational on the current sample; counter advances one per enabled cycle.
module gpio_poll_cmp
    import gpio_bus_pkg::*;
#(
    parameter int DW       = 32,
    parameter int POLL_MAX = 1023,
    parameter int CW       = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    input  logic [DW-1:0] rd,
    input  logic [DW-1:0] cmp,
    input  logic [DW-1:0] mask,
    output logic          hit,
    output logic          timeout
);

    logic [CW-1:0] cnt;
    logic          last;

    assign hit     = ((rd ^ cmp) & mask) == '0;
    // cnt holds reads already completed, so this sample is the final allowed one.
    assign last    = (cnt >= CW'(POLL_MAX - 1));
    assign timeout = en && last && !hit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != CW'(POLL_MAX))) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/gpio_bus_master.sv
// GPIO bus initiator: read/write/poll commands -> bus cycles; rsp 2 cycles after accept (1 on error, +1 write with READBACK_VERIFY_EN).
// One command in flight; cmd_ready only in IDLE, responses are never back-pressured.
module gpio_bus_master
    import gpio_bus_pkg::*;
#(
    parameter int DW       = 32,
    parameter int POLL_MAX = 1023,
    parameter int CW       = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [1:0]    cmd_addr,
    input  logic [DW-1:0] cmd_wdata,
    input  logic [DW-1:0] cmd_mask,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_err,
    output logic          rsp_timeout,
    output logic [1:0]    A,
    output logic          WE,
    output logic [DW-1:0] WD,
    input  logic [DW-1:0] RD
);

    state_t        state, state_d;
    logic [1:0]    a_d;
    logic          we_d, rdy_d, rsp_valid_d, rsp_err_d, rsp_timeout_d;
    logic [DW-1:0] wd_d, rsp_data_d, cmp_q, cmp_d, mask_q, mask_d;
    logic          poll_clr, poll_en, poll_hit, poll_timeout;

    gpio_poll_cmp #(.DW(DW), .POLL_MAX(POLL_MAX), .CW(CW)) u_poll (
        .clk     (clk),
        .rst     (rst),
        .clr     (poll_clr),
        .en      (poll_en),
        .rd      (RD),
        .cmp     (cmp_q),
        .mask    (mask_q),
        .hit     (poll_hit),
        .timeout (poll_timeout)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            A           <= '0;
            WE          <= 1'b0;
            WD          <= '0;
            cmd_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            cmp_q       <= '0;
            mask_q      <= '0;
        end else begin
            state       <= state_d;
            A           <= a_d;
            WE          <= we_d;
            WD          <= wd_d;
            cmd_ready   <= rdy_d;
            rsp_valid   <= rsp_valid_d;
            rsp_data    <= rsp_data_d;
            rsp_err     <= rsp_err_d;
            rsp_timeout <= rsp_timeout_d;
            cmp_q       <= cmp_d;
            mask_q      <= mask_d;
        end
    end

    always_comb begin
        state_d       = state;
        a_d           = A;
        we_d          = 1'b0;
        wd_d          = WD;
        rdy_d         = 1'b0;
        rsp_valid_d   = 1'b0;
        rsp_data_d    = rsp_data;
        rsp_err_d     = 1'b0;
        rsp_timeout_d = 1'b0;
        cmp_d         = cmp_q;
        mask_d        = mask_q;
        poll_clr      = 1'b0;
        poll_en       = 1'b0;
        case (state)
            ST_IDLE: begin
                rdy_d = 1'b1;
                if (cmd_valid && cmd_ready) begin
                    rdy_d    = 1'b0;
                    cmp_d    = cmd_wdata;
                    mask_d   = cmd_mask;
                    poll_clr = 1'b1;
                    // Rejected commands go straight to RESP and never touch the bus.
                    if (cmd_op == OP_RSVD || (cmd_op == OP_WRITE && is_input_reg(cmd_addr))) begin
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else begin
                        a_d = cmd_addr;
                        case (cmd_op)
                            OP_READ:  state_d = ST_RD;
                            OP_WRITE: begin
                                state_d = ST_WR;
                                we_d    = 1'b1;
                                wd_d    = cmd_wdata;
                            end
                            default:  state_d = ST_POLL;
                        endcase
                    end
                end
            end
            ST_RD: begin
                rsp_data_d  = RD;
                rsp_valid_d = 1'b1;
                state_d     = ST_RESP;
            end
            ST_WR: begin
                rsp_data_d = cmp_q;
`ifdef READBACK_VERIFY_EN
                state_d    = ST_VFY;
`else
                rsp_valid_d = 1'b1;
                state_d     = ST_RESP;
`endif
            end
`ifdef READBACK_VERIFY_EN
            ST_VFY: begin
                rsp_valid_d = 1'b1;
                state_d     = ST_RESP;
                if (RD != cmp_q) begin
                    rsp_err_d  = 1'b1;
                    rsp_data_d = RD;
                end
            end
`endif
            ST_POLL: begin
                poll_en    = 1'b1;
                rsp_data_d = RD;
                if (poll_hit) begin
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end else if (poll_timeout) begin
                    rsp_valid_d   = 1'b1;
                    rsp_timeout_d = 1'b1;
                    state_d       = ST_RESP;
                end
            end
            ST_RESP: begin
                rdy_d   = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_gpio_bus_master.sv
// Bench for gpio_bus_master: GPIO register model on the bus, directed scenarios and randomized commands vs a reference model.
module tb_gpio_bus_master;

    localparam int DW = 32;
    localparam int PM = 6;
    localparam int CW = 3;
`ifdef READBACK_VERIFY_EN
    localparam int WR_LAT = 3;
`else
    localparam int WR_LAT = 2;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0, cmd_ready;
    logic [1:0]    cmd_op = '0, cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0, cmd_mask = '0;
    logic          rsp_valid, rsp_err, rsp_timeout, WE;
    logic [DW-1:0] rsp_data, WD, RD;
    logic [1:0]    A;

    logic [DW-1:0] gpi1 = '0, gpi2 = '0, gpo1, gpo2;
    logic [DW-1:0] seq [1:PM];
    bit            seq_on = 1'b0;
    int            bad_we = 0;
    int            n_checks = 0, n_fail = 0;

    int            r_lat, r_we_n, r_reads, r_wait;
    logic [DW-1:0] r_data, r_we_d;
    logic [1:0]    r_we_a;
    logic          r_err, r_to, r_pulse1, r_rdy_next;

    int            e_lat, e_reads, e_we;
    logic [DW-1:0] e_data;
    logic          e_err, e_to;

    always #5 clk = ~clk;

    gpio_bus_master #(.DW(DW), .POLL_MAX(PM), .CW(CW)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_mask(cmd_mask),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .A(A), .WE(WE), .WD(WD), .RD(RD)
    );

    always_comb begin
        case (A)
            2'd0:    RD = gpi1;
            2'd1:    RD = gpi2;
            2'd2:    RD = gpo1;
            default: RD = gpo2;
        endcase
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            gpo1 <= '0;
            gpo2 <= '0;
        end else if (WE === 1'b1) begin
            if (A === 2'd2) gpo1 <= WD;
            else if (A === 2'd3) gpo2 <= WD;
            else bad_we <= bad_we + 1;
        end
    end

    function automatic logic [DW-1:0] cur(input logic [1:0] a);
        case (a)
            2'd0:    return gpi1;
            2'd1:    return gpi2;
            2'd2:    return gpo1;
            default: return gpo2;
        endcase
    endfunction

    // Expected response from the command rules: error / one read / one write / up to PM polled reads.
    task automatic model(input logic [1:0] op, input logic [1:0] addr, input logic [DW-1:0] wd, input logic [DW-1:0] mk);
        bit hit = 1'b0;
        e_err = 1'b0; e_to = 1'b0; e_we = 0; e_reads = 0; e_data = '0;
        if (op == 2'd3 || (op == 2'd1 && addr[1] == 1'b0)) begin
            e_err = 1'b1; e_lat = 1;
        end else if (op == 2'd0) begin
            e_lat = 2; e_data = cur(addr); e_reads = 1;
        end else if (op == 2'd1) begin
            e_lat = WR_LAT; e_data = wd; e_we = 1;
        end else begin
            for (int i = 1; i <= PM; i++) begin
                e_data  = (seq_on) ? seq[i] : cur(addr);
                e_reads = i;
                if (((e_data ^ wd) & mk) == '0) begin
                    hit = 1'b1;
                    break;
                end
            end
            e_to  = !hit;
            e_lat = e_reads + 1;
        end
    endtask

    // Drives one command and records what the bus and response port did; r_lat = -1 if nothing came back.
    task automatic do_cmd(input bit sync, input logic [1:0] op, input logic [1:0] addr,
                          input logic [DW-1:0] wd, input logic [DW-1:0] mk);
        if (sync) @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_wdata = wd; cmd_mask = mk;
        r_lat = -1; r_we_n = 0; r_reads = 0; r_wait = 0; r_pulse1 = 1'b0; r_rdy_next = 1'b0;
        r_data = '0; r_err = 1'b0; r_to = 1'b0; r_we_a = '0; r_we_d = '0;
        while (cmd_ready !== 1'b1 && r_wait < 20) begin
            @(negedge clk);
            r_wait++;
        end
        if (cmd_ready !== 1'b1) begin
            cmd_valid = 1'b0;
            return;
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int c = 1; c <= PM + 8; c++) begin
            if (seq_on && c <= PM) begin
                if (addr == 2'd0) gpi1 = seq[c];
                else gpi2 = seq[c];
            end
            if (WE === 1'b1) begin
                r_we_n++; r_we_a = A; r_we_d = WD;
            end
            if (rsp_valid === 1'b1) begin
                r_lat = c;
                break;
            end
            if (A === addr && WE === 1'b0) r_reads++;
            @(negedge clk);
        end
        if (r_lat < 0) return;
        r_data = rsp_data; r_err = rsp_err; r_to = rsp_timeout;
        @(negedge clk);
        r_pulse1   = (rsp_valid === 1'b0);
        r_rdy_next = cmd_ready;
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        #1;
        n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", cmd_ready); end
        n_checks++; if ({WE, A, WD} !== '0) begin n_fail++; $display("FAIL reset_bus: WE=%b A=%0d WD=%h want all 0", WE, A, WD); end
        n_checks++; if ({rsp_valid, rsp_err, rsp_timeout, rsp_data} !== '0) begin
            n_fail++; $display("FAIL reset_rsp: valid=%b err=%b to=%b data=%h want all 0", rsp_valid, rsp_err, rsp_timeout, rsp_data);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL idle_ready: got %b want 1", cmd_ready); end
    endtask

    task automatic test_write();
        do_cmd(1'b1, 2'd1, 2'd2, 32'hDEADBEEF, '0);
        n_checks++; if (r_lat !== WR_LAT) begin n_fail++; $display("FAIL write_lat: got %0d want %0d", r_lat, WR_LAT); end
        n_checks++; if (r_data !== 32'hDEADBEEF || r_err !== 1'b0) begin n_fail++; $display("FAIL write_rsp: data=%h err=%b want DEADBEEF 0", r_data, r_err); end
        n_checks++; if (r_we_n !== 1 || r_we_a !== 2'd2 || r_we_d !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL write_bus: we_cycles=%0d A=%0d WD=%h want 1 2 DEADBEEF", r_we_n, r_we_a, r_we_d);
        end
        n_checks++; if (gpo1 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL write_gpo1: got %h want DEADBEEF", gpo1); end
        n_checks++; if (r_pulse1 !== 1'b1) begin n_fail++; $display("FAIL write_pulse: rsp_valid stayed high"); end
    endtask

    task automatic test_read();
        gpi2 = 32'h0000_1234;
        do_cmd(1'b1, 2'd0, 2'd1, $urandom, $urandom);
        n_checks++; if (r_lat !== 2) begin n_fail++; $display("FAIL read_lat: got %0d want 2", r_lat); end
        n_checks++; if (r_data !== 32'h0000_1234 || r_err !== 1'b0) begin n_fail++; $display("FAIL read_rsp: data=%h err=%b want 00001234 0", r_data, r_err); end
        n_checks++; if (r_we_n !== 0) begin n_fail++; $display("FAIL read_we: we_cycles=%0d want 0", r_we_n); end
    endtask

    task automatic test_poll_match();
        for (int i = 1; i <= PM; i++) seq[i] = $urandom & ~32'h1;
        seq[5] = seq[5] | 32'h1;
        seq_on = 1'b1;
        do_cmd(1'b1, 2'd2, 2'd0, 32'h1, 32'h1);
        seq_on = 1'b0;
        n_checks++; if (r_lat !== 6) begin n_fail++; $display("FAIL poll_lat: got %0d want 6", r_lat); end
        n_checks++; if (r_data[0] !== 1'b1 || r_to !== 1'b0) begin n_fail++; $display("FAIL poll_rsp: data=%h to=%b want bit0=1 0", r_data, r_to); end
        n_checks++; if (r_reads !== 5) begin n_fail++; $display("FAIL poll_reads: got %0d want 5", r_reads); end
    endtask

    task automatic test_poll_timeout();
        for (int i = 1; i <= PM; i++) seq[i] = $urandom & ~32'h1;
        seq_on = 1'b1;
        do_cmd(1'b1, 2'd2, 2'd1, 32'h1, 32'h1);
        seq_on = 1'b0;
        n_checks++; if (r_lat !== PM + 1) begin n_fail++; $display("FAIL poll_to_lat: got %0d want %0d", r_lat, PM + 1); end
        n_checks++; if (r_to !== 1'b1 || r_data !== seq[PM]) begin n_fail++; $display("FAIL poll_to_rsp: to=%b data=%h want 1 %h", r_to, r_data, seq[PM]); end
        n_checks++; if (r_reads !== PM) begin n_fail++; $display("FAIL poll_to_reads: got %0d want %0d", r_reads, PM); end
        do_cmd(1'b1, 2'd2, 2'd3, 32'h0, 32'h0);
        n_checks++; if (r_lat !== 2 || r_to !== 1'b0) begin n_fail++; $display("FAIL poll_mask0: lat=%0d to=%b want 2 0", r_lat, r_to); end
    endtask

    task automatic test_errors();
        do_cmd(1'b1, 2'd1, 2'd0, $urandom, '0);
        n_checks++; if (r_lat !== 1 || r_err !== 1'b1 || r_to !== 1'b0) begin n_fail++; $display("FAIL err_wr_gpi: lat=%0d err=%b to=%b want 1 1 0", r_lat, r_err, r_to); end
        n_checks++; if (r_we_n !== 0) begin n_fail++; $display("FAIL err_wr_we: we_cycles=%0d want 0", r_we_n); end
        do_cmd(1'b1, 2'd3, 2'($urandom_range(0, 3)), $urandom, $urandom);
        n_checks++; if (r_lat !== 1 || r_err !== 1'b1 || r_we_n !== 0) begin n_fail++; $display("FAIL err_op11: lat=%0d err=%b we=%0d want 1 1 0", r_lat, r_err, r_we_n); end
    endtask

    task automatic test_reset_mid_poll();
        logic [DW-1:0] v;
        int            wait_n = 0;
        bit            saw = 1'b0;
        gpi1 = 32'h0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'd2; cmd_addr = 2'd0; cmd_wdata = 32'h1; cmd_mask = 32'h1;
        while (cmd_ready !== 1'b1 && wait_n < 20) begin @(negedge clk); wait_n++; end
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        n_checks++; if (WE !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b0) begin
            n_fail++; $display("FAIL midreset_out: WE=%b rsp_valid=%b cmd_ready=%b want 0 0 0", WE, rsp_valid, cmd_ready);
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (PM + 2) begin @(negedge clk); if (rsp_valid === 1'b1) saw = 1'b1; end
        n_checks++; if (saw !== 1'b0) begin n_fail++; $display("FAIL midreset_rsp: aborted poll produced rsp_valid=1, want none"); end
        v = $urandom;
        gpi1 = v;
        do_cmd(1'b0, 2'd0, 2'd0, '0, '0);
        n_checks++; if (r_lat !== 2 || r_data !== v) begin n_fail++; $display("FAIL midreset_read: lat=%0d data=%h want 2 %h", r_lat, r_data, v); end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] v = $urandom;
        do_cmd(1'b1, 2'd1, 2'd3, v, '0);
        n_checks++; if (r_rdy_next !== 1'b1) begin n_fail++; $display("FAIL b2b_ready: cmd_ready=%b after RESP, want 1", r_rdy_next); end
        do_cmd(1'b0, 2'd0, 2'd3, '0, '0);
        n_checks++; if (r_wait !== 0 || r_lat !== 2 || r_data !== v) begin
            n_fail++; $display("FAIL b2b_read: wait=%0d lat=%0d data=%h want 0 2 %h", r_wait, r_lat, r_data, v);
        end
    endtask

    task automatic test_random();
        logic [1:0]    op, addr;
        logic [DW-1:0] wd, mk;
        for (int n = 0; n < 40; n++) begin
            gpi1 = $urandom; gpi2 = $urandom;
            op = 2'($urandom_range(0, 3)); addr = 2'($urandom_range(0, 3)); wd = $urandom;
            case ($urandom_range(0, 3))
                0:       mk = '0;
                3:       mk = $urandom;
                default: mk = 32'h1 << $urandom_range(0, 31);
            endcase
            seq_on = (op == 2'd2 && addr[1] == 1'b0);
            for (int i = 1; i <= PM; i++) seq[i] = $urandom;
            model(op, addr, wd, mk);
            do_cmd(1'b1, op, addr, wd, mk);
            seq_on = 1'b0;
            n_checks++; if (r_lat !== e_lat || r_err !== e_err || r_to !== e_to) begin
                n_fail++; $display("FAIL rnd%0d_ctl: op=%0d addr=%0d lat=%0d err=%b to=%b want %0d %b %b", n, op, addr, r_lat, r_err, r_to, e_lat, e_err, e_to);
            end
            if (!e_err) begin
                n_checks++; if (r_data !== e_data) begin n_fail++; $display("FAIL rnd%0d_data: op=%0d got %h want %h", n, op, r_data, e_data); end
            end
            if (op == 2'd2) begin
                n_checks++; if (r_reads !== e_reads) begin n_fail++; $display("FAIL rnd%0d_reads: got %0d want %0d", n, r_reads, e_reads); end
            end
            if (e_we == 1) begin
                n_checks++; if (cur(addr) !== wd) begin n_fail++; $display("FAIL rnd%0d_gpo: reg %0d got %h want %h", n, addr, cur(addr), wd); end
            end
            n_checks++; if (r_we_n !== e_we || r_pulse1 !== 1'b1 || r_rdy_next !== 1'b1) begin
                n_fail++; $display("FAIL rnd%0d_hs: we_cycles=%0d pulse_ok=%b ready_next=%b want %0d 1 1", n, r_we_n, r_pulse1, r_rdy_next, e_we);
            end
        end
        n_checks++; if (bad_we !== 0) begin n_fail++; $display("FAIL we_input_reg: WE asserted %0d times on addr 0/1, want 0", bad_we); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_poll_match();
        test_poll_timeout();
        test_errors();
        test_reset_mid_poll();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
